// File: rtl/opsum_requant_packer.sv
// Requantises conv_unit partial sums to uint8 and packs four results
// per 32-bit output buffer word, one tile per cfg_start.
module opsum_requant_packer #(
    parameter int PSUM_W = 32,
    parameter int OUT_W  = 8,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic [CNT_W-1:0]        cfg_num_psum,
    input  logic [PSUM_W-1:0]       cfg_bias,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_relu,
    input  logic [OUT_W-1:0]        cfg_zero_point,
    input  logic                    valid_op,
    output logic                    ready_op,
    input  logic [PSUM_W-1:0]       psum_in,
    output logic                    ob_valid,
    input  logic                    ob_ready,
    output logic [PACK_N*OUT_W-1:0] ob_data,
    output logic [PACK_N-1:0]       ob_strb,
    output logic                    ob_last,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int AW    = PSUM_W + 2;
    localparam int WW    = PACK_N * OUT_W;
    localparam logic signed [AW-1:0] QMAX = AW'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PSUM_W-1:0]  bias_q;
    logic [4:0]         shift_q;
    logic               relu_q;
    logic [OUT_W-1:0]   zp_q;
    logic [WW-1:0]      pack_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ob_valid_q;
    logic [WW-1:0]      ob_data_q;
    logic [PACK_N-1:0]  ob_strb_q;
    logic               ob_last_q;
    logic               done_q;

    logic                 accept;
    logic                 last_psum;
    logic                 word_full;
    logic signed [AW-1:0] s_w;
    logic signed [AW-1:0] r_w;
    logic signed [AW-1:0] y_w;
    logic signed [AW-1:0] zp_w;
    logic signed [AW-1:0] z_w;
    logic [OUT_W-1:0]     q_d;
    logic [WW-1:0]        word_d;
    logic [PACK_N-1:0]    strb_d;

    assign ready_op  = (state_q == RUN) && (!ob_valid_q || ob_ready);
    assign accept    = valid_op && ready_op;
    assign last_psum = (cnt_q == num_q - CNT_W'(1));
    assign word_full = (idx_q == IDX_W'(PACK_N - 1));

    // 34-bit datapath: bias add plus rounding term cannot overflow
    always_comb begin
        s_w  = AW'(signed'(psum_in)) + AW'(signed'(bias_q));
        r_w  = (shift_q == 5'd0) ? '0 : (AW'(1) << (shift_q - 5'd1));
        y_w  = (s_w + r_w) >>> shift_q;
        if (relu_q && y_w < 0) y_w = '0;
        zp_w = signed'(AW'(zp_q));
        z_w  = y_w + zp_w;
        if (z_w < 0)         q_d = '0;
        else if (z_w > QMAX) q_d = '1;
        else                 q_d = z_w[OUT_W-1:0];
    end

    always_comb begin
        word_d = pack_q;
        word_d[idx_q*OUT_W +: OUT_W] = q_d;
        strb_d = '0;
        for (int k = 0; k < PACK_N; k++)
            strb_d[k] = (IDX_W'(k) <= idx_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            num_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            zp_q       <= '0;
            pack_q     <= '0;
            idx_q      <= '0;
            ob_valid_q <= 1'b0;
            ob_data_q  <= '0;
            ob_strb_q  <= '0;
            ob_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ob_valid_q && ob_ready) begin
                ob_valid_q <= 1'b0;
                ob_data_q  <= '0;
                ob_strb_q  <= '0;
                ob_last_q  <= 1'b0;
            end
            // a word loaded here overrides the handshake clear above
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (word_full || last_psum) begin
                    ob_valid_q <= 1'b1;
                    ob_data_q  <= word_d;
                    ob_strb_q  <= strb_d;
                    ob_last_q  <= last_psum;
                    pack_q     <= '0;
                    idx_q      <= '0;
                end else begin
                    pack_q <= word_d;
                    idx_q  <= idx_q + IDX_W'(1);
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        num_q   <= cfg_num_psum;
                        bias_q  <= cfg_bias;
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                        zp_q    <= cfg_zero_point;
                        cnt_q   <= '0;
                        pack_q  <= '0;
                        idx_q   <= '0;
                        if (cfg_num_psum == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept && last_psum) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (ob_valid_q && ob_ready && ob_last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ob_valid = ob_valid_q;
    assign ob_data  = ob_data_q;
    assign ob_strb  = ob_strb_q;
    assign ob_last  = ob_last_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule
